// File: rtl/ddram_cached_port.sv
// ddram_cached_port
// Single-client bridge from a byte-addressed CPU port (DW bits) onto the
// 64-bit MiSTer DDRAM Avalon port. A small direct-mapped read cache sits in
// front of DDRAM. Writes go straight through and also patch any cached copy,
// so the cache never holds stale data. A read miss can optionally fetch the
// following 64-bit line as a second beat (next-line prefetch).
module ddram_cached_port #(
    parameter int         DW       = 8,        // CPU data width: 8, 16, 32 or 64
    parameter int         LINES    = 4,        // cache lines, power of two, >= 2
    parameter int         PREFETCH = 1,        // 1: read misses fetch two lines
    parameter logic [3:0] BASE     = 4'b0011   // DDRAM_ADDR[28:25] window
) (
    input  logic          DDRAM_CLK,
    input  logic          reset,
    input  logic          DDRAM_BUSY,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [28:0]   DDRAM_ADDR,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY,
    output logic          DDRAM_RD,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_WE,
    input  logic [27:0]   wraddr,
    input  logic [DW-1:0] din,
    input  logic          we_req,
    output logic          we_ack,
    input  logic [27:0]   rdaddr,
    output logic [DW-1:0] dout,
    input  logic          rd_req,
    output logic          rd_rdy,
    input  logic          flush,
    output logic [1:0]    dbg_state
);

    localparam int         IW       = $clog2(LINES);   // index bits
    localparam int         TW       = 25 - IW;         // tag bits
    localparam int         NB       = DW / 8;          // bytes per CPU word
    localparam logic [2:0] OFF_MASK = 3'(~(NB - 1));   // clears sub-word offset bits
    localparam logic [7:0] BE_BASE  = 8'((1 << NB) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    state_t state, next_state;

    // Cache storage
    logic [63:0]      line_data  [LINES];
    logic [TW-1:0]    line_tag   [LINES];
    logic [LINES-1:0] line_valid;

    // Control registers
    logic        flush_pend;
    logic        old_rd;
    logic [24:0] req_line;     // 64-bit line address of the outstanding miss
    logic [2:0]  req_off;      // byte offset of the outstanding miss

    // FSM action strobes
    logic do_flush, do_write, do_hit, do_miss, do_fill1, do_fill2, wr_done, cmd_taken;

    // Read-side address decode
    logic [2:0]    rd_off;
    logic [IW-1:0] rd_idx, rd_idx_nx;
    logic [TW-1:0] rd_tag;
    logic          rd_hit;

    assign rd_off    = rdaddr[2:0] & OFF_MASK;
    assign rd_idx    = rdaddr[3 +: IW];
    assign rd_idx_nx = rd_idx + IW'(1);
    assign rd_tag    = rdaddr[27:3+IW];
    assign rd_hit    = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);

    // Write-side address decode and byte lanes
    logic [2:0]    wr_off;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          wr_hit;
    logic          wr_pend;
    logic [7:0]    wr_be;
    logic [63:0]   wr_mask;
    logic [63:0]   din_rep;
    logic [63:0]   wr_merge;

    assign wr_off   = wraddr[2:0] & OFF_MASK;
    assign wr_idx   = wraddr[3 +: IW];
    assign wr_tag   = wraddr[27:3+IW];
    assign wr_hit   = line_valid[wr_idx] && (line_tag[wr_idx] == wr_tag);
    assign wr_pend  = (we_req != we_ack);
    assign wr_be    = BE_BASE << wr_off;
    assign din_rep  = {(64/DW){din}};
    assign wr_merge = (line_data[wr_idx] & ~wr_mask) | (din_rep & wr_mask);

    // Fill targets: the requested line and, for prefetch, the next line
    // address (wrapping at 2^25), which always lands on index+1 mod LINES.
    logic [IW-1:0] fill_idx, pf_idx;
    logic [TW-1:0] fill_tag, pf_tag;
    logic [24:0]   pf_line;
    logic          fill_valid;

    assign fill_idx   = req_line[IW-1:0];
    assign fill_tag   = req_line[24:IW];
    assign pf_line    = req_line + 25'd1;
    assign pf_idx     = pf_line[IW-1:0];
    assign pf_tag     = pf_line[24:IW];
    assign fill_valid = !(flush_pend || flush);

    assign dbg_state = state;

    // Expand byte enables into a bit mask for merging write data into a line
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < 8; b++) begin
            wr_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    // FSM state register
    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and single-cycle action strobes
    always_comb begin
        next_state = state;
        do_flush   = 1'b0;
        do_write   = 1'b0;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill1   = 1'b0;
        do_fill2   = 1'b0;
        wr_done    = 1'b0;
        cmd_taken  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!DDRAM_BUSY) begin
                    if (flush_pend) begin
                        do_flush = 1'b1;
                    end else if (wr_pend) begin
                        do_write   = 1'b1;
                        next_state = WR;
                    end else if (!rd_rdy) begin
                        if (rd_hit) begin
                            do_hit = 1'b1;
                        end else begin
                            do_miss    = 1'b1;
                            next_state = RD1;
                        end
                    end
                end
            end
            WR: begin
                if (!DDRAM_BUSY) begin
                    wr_done    = 1'b1;
                    next_state = IDLE;
                end
            end
            RD1: begin
                if (DDRAM_RD && !DDRAM_BUSY) cmd_taken = 1'b1;
                if (DDRAM_DOUT_READY) begin
                    do_fill1   = 1'b1;
                    next_state = (PREFETCH != 0) ? RD2 : IDLE;
                end
            end
            RD2: begin
                if (DDRAM_DOUT_READY) begin
                    do_fill2   = 1'b1;
                    next_state = IDLE;
                end
            end
        endcase
    end

    // CPU handshakes, read data register and DDRAM command registers
    always_ff @(posedge DDRAM_CLK) begin
        old_rd <= rd_req;
        if (reset) begin
            rd_rdy         <= 1'b1;
            dout           <= '0;
            we_ack         <= we_req;   // a write pending across reset is dropped
            flush_pend     <= 1'b0;
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BE       <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BURSTCNT <= '0;
            req_line       <= '0;
            req_off        <= '0;
        end else begin
            // A rising rd_req only counts while no read is outstanding
            if (rd_req && !old_rd && rd_rdy) rd_rdy <= 1'b0;

            if (flush)         flush_pend <= 1'b1;
            else if (do_flush) flush_pend <= 1'b0;

            if (do_hit) begin
                dout   <= line_data[rd_idx][{rd_off, 3'b000} +: DW];
                rd_rdy <= 1'b1;
            end
            if (do_fill1) begin
                dout   <= DDRAM_DOUT[{req_off, 3'b000} +: DW];
                rd_rdy <= 1'b1;
            end

            if (do_write) begin
                DDRAM_WE       <= 1'b1;
                DDRAM_ADDR     <= {BASE, wraddr[27:3]};
                DDRAM_BE       <= wr_be;
                DDRAM_DIN      <= din_rep;
                DDRAM_BURSTCNT <= 8'd1;
            end
            if (wr_done) begin
                DDRAM_WE <= 1'b0;
                we_ack   <= we_req;
            end

            if (do_miss) begin
                DDRAM_RD       <= 1'b1;
                DDRAM_ADDR     <= {BASE, rdaddr[27:3]};
                DDRAM_BE       <= 8'hFF;
                DDRAM_BURSTCNT <= 8'(1 + PREFETCH);
                req_line       <= rdaddr[27:3];
                req_off        <= rd_off;
            end
            if (cmd_taken || do_fill1) DDRAM_RD <= 1'b0;
        end
    end

    // Valid bits: cleared by reset/flush, dropped for lines about to be refilled
    always_ff @(posedge DDRAM_CLK) begin
        if (reset || do_flush) begin
            line_valid <= '0;
        end else if (do_miss) begin
            line_valid[rd_idx] <= 1'b0;
            if (PREFETCH != 0) line_valid[rd_idx_nx] <= 1'b0;
        end else if (do_fill1) begin
            line_valid[fill_idx] <= fill_valid;
        end else if (do_fill2) begin
            line_valid[pf_idx] <= fill_valid;
        end
    end

    // Line data and tags: patched by write hits, loaded by read beats
    // NOTE: the data/tag arrays are deliberately not reset; line_valid alone decides whether contents are usable.
    always_ff @(posedge DDRAM_CLK) begin
        if (do_write && wr_hit) begin
            line_data[wr_idx] <= wr_merge;
        end
        if (do_fill1) begin
            line_data[fill_idx] <= DDRAM_DOUT;
            line_tag[fill_idx]  <= fill_tag;
        end
        if (do_fill2) begin
            line_data[pf_idx] <= DDRAM_DOUT;
            line_tag[pf_idx]  <= pf_tag;
        end
    end

endmodule

// File: tb/tb_ddram_cached_port.sv
// Testbench for ddram_cached_port (DW=16, LINES=4, PREFETCH=1).
// A behavioural DDRAM responder answers commands; read data expectations are
// queued by the stimulus and checked by a monitor whenever rd_rdy rises.
module tb_ddram_cached_port;

    localparam int DW = 16;

    logic          DDRAM_CLK = 1'b0;
    logic          reset = 1'b1;
    logic          DDRAM_BUSY = 1'b0;
    logic [7:0]    DDRAM_BURSTCNT;
    logic [28:0]   DDRAM_ADDR;
    logic [63:0]   DDRAM_DOUT = '0;
    logic          DDRAM_DOUT_READY = 1'b0;
    logic          DDRAM_RD;
    logic [63:0]   DDRAM_DIN;
    logic [7:0]    DDRAM_BE;
    logic          DDRAM_WE;
    logic [27:0]   wraddr = '0;
    logic [DW-1:0] din = '0;
    logic          we_req = 1'b0;
    logic          we_ack;
    logic [27:0]   rdaddr = '0;
    logic [DW-1:0] dout;
    logic          rd_req = 1'b0;
    logic          rd_rdy;
    logic          flush = 1'b0;
    logic [1:0]    dbg_state;

    ddram_cached_port #(
        .DW(DW), .LINES(4), .PREFETCH(1), .BASE(4'b0011)
    ) dut (
        .DDRAM_CLK       (DDRAM_CLK),
        .reset           (reset),
        .DDRAM_BUSY      (DDRAM_BUSY),
        .DDRAM_BURSTCNT  (DDRAM_BURSTCNT),
        .DDRAM_ADDR      (DDRAM_ADDR),
        .DDRAM_DOUT      (DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD        (DDRAM_RD),
        .DDRAM_DIN       (DDRAM_DIN),
        .DDRAM_BE        (DDRAM_BE),
        .DDRAM_WE        (DDRAM_WE),
        .wraddr          (wraddr),
        .din             (din),
        .we_req          (we_req),
        .we_ack          (we_ack),
        .rdaddr          (rdaddr),
        .dout            (dout),
        .rd_req          (rd_req),
        .rd_rdy          (rd_rdy),
        .flush           (flush),
        .dbg_state       (dbg_state)
    );

    always #5 DDRAM_CLK = ~DDRAM_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- DDRAM responder ----------------
    typedef struct packed {
        logic [24:0] la;
        logic [31:0] due;
    } beat_t;

    logic [63:0]  mem [logic [24:0]];
    beat_t        beat_q [$];
    int unsigned  cyc = 0;
    int unsigned  rd_lat = 2;
    int unsigned  rd_cmds = 0;
    int unsigned  wr_cmds = 0;
    logic [7:0]   last_burst = '0;
    logic [7:0]   last_be = '0;
    logic [28:0]  last_addr = '0;
    logic [63:0]  last_din = '0;

    always @(posedge DDRAM_CLK) begin
        beat_t       b;
        logic [63:0] w;
        logic [24:0] la;
        cyc++;
        DDRAM_DOUT_READY <= 1'b0;
        if (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
            b = beat_q.pop_front();
            DDRAM_DOUT       <= mem.exists(b.la) ? mem[b.la] : 64'h0;
            DDRAM_DOUT_READY <= 1'b1;
        end
        if (DDRAM_RD && !DDRAM_BUSY) begin
            rd_cmds++;
            last_burst = DDRAM_BURSTCNT;
            last_addr  = DDRAM_ADDR;
            for (int i = 0; i < int'(DDRAM_BURSTCNT); i++) begin
                b.la  = DDRAM_ADDR[24:0] + 25'(i);
                b.due = cyc + rd_lat + unsigned'(i);
                beat_q.push_back(b);
            end
        end
        if (DDRAM_WE && !DDRAM_BUSY) begin
            wr_cmds++;
            last_be   = DDRAM_BE;
            last_addr = DDRAM_ADDR;
            last_din  = DDRAM_DIN;
            la = DDRAM_ADDR[24:0];
            w  = mem.exists(la) ? mem[la] : 64'h0;
            for (int i = 0; i < 8; i++) begin
                if (DDRAM_BE[i]) w[8*i +: 8] = DDRAM_DIN[8*i +: 8];
            end
            mem[la] = w;
        end
    end

    // ---------------- scoreboard monitor ----------------
    string         exp_name_q [$];
    logic [DW-1:0] exp_val_q [$];
    bit            sb_mute = 1'b1;
    logic          prev_rdy = 1'b1;

    always @(negedge DDRAM_CLK) begin
        string         nm;
        logic [DW-1:0] ev;
        if (!sb_mute && rd_rdy && !prev_rdy) begin
            if (exp_val_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rdy: got dout %h with no read outstanding", dout);
            end else begin
                nm = exp_name_q.pop_front();
                ev = exp_val_q.pop_front();
                check(nm, 64'(dout), 64'(ev));
            end
        end
        prev_rdy = rd_rdy;
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_read(input string name, input logic [27:0] a,
                           input logic [DW-1:0] exp, input bit hit);
        int unsigned rd0;
        int          edges;
        rd0   = rd_cmds;
        edges = 0;
        exp_name_q.push_back(name);
        exp_val_q.push_back(exp);
        @(negedge DDRAM_CLK);
        rdaddr = a;
        rd_req = 1'b1;
        do begin
            @(negedge DDRAM_CLK);
            edges++;
        end while (!rd_rdy && edges < 200);
        check({name, "_rdy"}, 64'(rd_rdy), 64'd1);
        rd_req = 1'b0;
        repeat (4) @(negedge DDRAM_CLK);
        if (hit) begin
            check({name, "_latency"}, 64'(edges), 64'd2);
            check({name, "_no_rd_cmd"}, 64'(rd_cmds - rd0), 64'd0);
        end else begin
            check({name, "_rd_cmds"}, 64'(rd_cmds - rd0), 64'd1);
            check({name, "_burst"}, 64'(last_burst), 64'd2);
            check({name, "_addr"}, 64'(last_addr), 64'({4'b0011, a[27:3]}));
        end
    endtask

    task automatic do_write(input string name, input logic [27:0] a, input logic [DW-1:0] d,
                            input logic [7:0] be, input int busy_cycles);
        int unsigned wr0;
        int          n;
        wr0 = wr_cmds;
        @(negedge DDRAM_CLK);
        wraddr = a;
        din    = d;
        we_req = !we_req;
        n = 0;
        while (!DDRAM_WE && n < 50) begin
            @(negedge DDRAM_CLK);
            n++;
        end
        check({name, "_we"}, 64'(DDRAM_WE), 64'd1);
        if (busy_cycles > 0) begin
            DDRAM_BUSY = 1'b1;
            for (int i = 0; i < busy_cycles; i++) begin
                @(negedge DDRAM_CLK);
                check({name, "_we_held"}, 64'(DDRAM_WE), 64'd1);
                check({name, "_no_ack"}, 64'(we_ack), 64'(!we_req));
                check({name, "_state_wr"}, 64'(dbg_state), 64'd1);
            end
            DDRAM_BUSY = 1'b0;
        end
        @(negedge DDRAM_CLK);
        check({name, "_ack"}, 64'(we_ack), 64'(we_req));
        check({name, "_we_drop"}, 64'(DDRAM_WE), 64'd0);
        check({name, "_wr_cmds"}, 64'(wr_cmds - wr0), 64'd1);
        check({name, "_be"}, 64'(last_be), 64'(be));
        check({name, "_din"}, last_din, {4{d}});
        check({name, "_addr"}, 64'(last_addr), 64'({4'b0011, a[27:3]}));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        mem[25'h000000] = 64'h0123_4567_89AB_CDEF;   // 0x000
        mem[25'h000001] = 64'hFEDC_BA98_7654_3210;   // 0x008
        mem[25'h000004] = 64'h0000_0000_0000_2020;   // 0x020
        mem[25'h000021] = 64'h0000_0000_0000_C0DE;   // 0x108
        mem[25'h000040] = 64'h1111_2222_3333_4444;   // 0x200
        mem[25'h000041] = 64'h5555_6666_7777_8888;   // 0x208
        mem[25'h000080] = 64'hDEAD_BEEF_DEAD_BEEF;   // 0x400

        // Reset with a write request pending: it must be discarded.
        repeat (2) @(negedge DDRAM_CLK);
        we_req = 1'b1;
        repeat (2) @(negedge DDRAM_CLK);
        reset = 1'b0;
        repeat (3) @(negedge DDRAM_CLK);
        check("rst_rd_rdy", 64'(rd_rdy), 64'd1);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ddram_rd", 64'(DDRAM_RD), 64'd0);
        check("rst_ddram_we", 64'(DDRAM_WE), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_we_ack", 64'(we_ack), 64'(we_req));
        check("rst_no_write", 64'(wr_cmds), 64'd0);
        sb_mute = 1'b0;

        // Write-through then miss with prefetch, then prefetch hit.
        do_write("wr_100", 28'h100, 16'h005A, 8'h03, 0);
        do_read("rd_100_miss", 28'h100, 16'h005A, 1'b0);
        do_read("rd_108_pf_hit", 28'h108, 16'hC0DE, 1'b1);

        // Write hit updates the cached line at the right byte lanes.
        do_read("rd_202_miss", 28'h202, 16'h3333, 1'b0);
        do_write("wr_202_hit", 28'h202, 16'hBEEF, 8'h0C, 0);
        do_read("rd_202_hit", 28'h202, 16'hBEEF, 1'b1);
        do_read("rd_206_hit", 28'h206, 16'h1111, 1'b1);
        do_read("rd_208_pf_hit", 28'h208, 16'h8888, 1'b1);

        // Direct-mapped conflict on index 0.
        do_read("rd_000_miss", 28'h000, 16'hCDEF, 1'b0);
        do_read("rd_020_conflict", 28'h020, 16'h2020, 1'b0);
        do_read("rd_000_remiss", 28'h000, 16'hCDEF, 1'b0);

        // Controller stall during a write, top byte lanes.
        do_write("wr_306_busy", 28'h306, 16'h1234, 8'hC0, 5);
        do_read("rd_306_miss", 28'h306, 16'h1234, 1'b0);

        // Reset while waiting for read data; late beats must be ignored.
        rd_lat = 8;
        @(negedge DDRAM_CLK);
        rdaddr = 28'h400;
        rd_req = 1'b1;
        n = 0;
        do begin
            @(negedge DDRAM_CLK);
            n++;
        end while (dbg_state != 2'd2 && n < 50);
        check("mid_rd_state_rd1", 64'(dbg_state), 64'd2);
        sb_mute = 1'b1;
        reset   = 1'b1;
        @(negedge DDRAM_CLK);
        reset  = 1'b0;
        rd_req = 1'b0;
        check("mid_rst_rd_rdy", 64'(rd_rdy), 64'd1);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_ddram_rd", 64'(DDRAM_RD), 64'd0);
        check("mid_rst_dout", 64'(dout), 64'd0);
        repeat (15) @(negedge DDRAM_CLK);
        check("late_beat_state", 64'(dbg_state), 64'd0);
        check("late_beat_rd_rdy", 64'(rd_rdy), 64'd1);
        check("late_beat_dout", 64'(dout), 64'd0);
        check("late_beats_drained", 64'(beat_q.size()), 64'd0);
        sb_mute = 1'b0;
        rd_lat  = 2;

        // Reset cleared all lines; then flush clears them again.
        do_read("post_rst_miss", 28'h000, 16'hCDEF, 1'b0);
        do_read("post_rst_hit", 28'h000, 16'hCDEF, 1'b1);
        @(negedge DDRAM_CLK);
        flush = 1'b1;
        @(negedge DDRAM_CLK);
        flush = 1'b0;
        repeat (2) @(negedge DDRAM_CLK);
        do_read("post_flush_miss", 28'h008, 16'h3210, 1'b0);
        do_read("post_flush_000", 28'h000, 16'hCDEF, 1'b0);

        repeat (4) @(negedge DDRAM_CLK);
        check("scoreboard_drained", 64'(exp_val_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
